// File: rtl/axi_resp_packetizer_rr_if.sv
// Response-side bundle between the AXI B/R channels and the NoC injection port.
// The packetizer uses the slave modport; the environment driving beats uses master.
interface axi_resp_packetizer_rr_if #(
  parameter int TID_W       = 4,
  parameter int SRC_W       = 2,
  parameter int B_PAYLOAD_W = 4,
  parameter int R_PAYLOAD_W = 37,
  parameter int FLIT_WIDTH  = 32
);
  logic [B_PAYLOAD_W+SRC_W+TID_W-1:0] b_chan;
  logic                               b_valid;
  logic                               b_ready;
  logic [R_PAYLOAD_W+SRC_W+TID_W-1:0] r_chan;
  logic                               r_last;
  logic                               r_valid;
  logic                               r_ready;
  logic [FLIT_WIDTH-1:0]              flit_out;
  logic                               valid_out;
  logic                               ready_in;

  modport slave (
    input  b_chan, b_valid, r_chan, r_last, r_valid, ready_in,
    output b_ready, r_ready, flit_out, valid_out
  );

  modport master (
    output b_chan, b_valid, r_chan, r_last, r_valid, ready_in,
    input  b_ready, r_ready, flit_out, valid_out
  );
endinterface

// File: rtl/axi_resp_packetizer_rr.sv
// Round-robin B/R response merge that serialises each beat into a 1..N-flit NoC packet,
// with optional locking so an R burst stays contiguous on the link.
module axi_resp_packetizer_rr #(
  parameter int SLAVE_ID    = 0,
  parameter int TID_W       = 4,
  parameter int SRC_W       = 2,
  parameter int SLV_W       = 1,
  parameter int B_PAYLOAD_W = 4,
  parameter int R_PAYLOAD_W = 37,
  parameter int FLIT_WIDTH  = 32,
  parameter int LOCK_BURST  = 1
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  axi_resp_packetizer_rr_if.slave rsp_if
);

  localparam int FFW   = 2;
  localparam int HF    = TID_W + SRC_W + SLV_W + 1 + FFW;
  localparam int HS    = 1 + FFW;
  localparam int ROOM0 = FLIT_WIDTH - HF;
  localparam int ROOMK = FLIT_WIDTH - HS;

  localparam logic [1:0] FLIT_HEAD   = 2'b00;
  localparam logic [1:0] FLIT_BODY   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;
  localparam logic       OP_ID_WRITE = 1'b1;
  localparam logic       OP_ID_READ  = 1'b0;

  function automatic int flit_count(input int p);
    if (p <= ROOM0) return 1;
    return 1 + (p - ROOM0 + ROOMK - 1) / ROOMK;
  endfunction

  localparam int NB    = flit_count(B_PAYLOAD_W);
  localparam int NR    = flit_count(R_PAYLOAD_W);
  localparam int NMAX  = (NB > NR) ? NB : NR;
  localparam int PADW  = ROOM0 + (NMAX - 1) * ROOMK;
  localparam int IDX_W = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int TW1   = (TID_W > 0) ? TID_W : 1;
  localparam int SW1   = (SRC_W > 0) ? SRC_W : 1;

  localparam logic [IDX_W-1:0] NB_LAST   = IDX_W'(NB - 1);
  localparam logic [IDX_W-1:0] NR_LAST   = IDX_W'(NR - 1);
  localparam logic [TW1-1:0]   TID_MASK  = TW1'((64'd1 << TID_W) - 64'd1);
  localparam logic [SW1-1:0]   SRC_MASK  = SW1'((64'd1 << SRC_W) - 64'd1);
  localparam logic [63:0]      SLV_FIELD = 64'(SLAVE_ID) & ((64'd1 << SLV_W) - 64'd1);

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;

  // Zero-width fields are masked to 0 so they shift out of the header entirely.
  function automatic logic [FLIT_WIDTH-1:0] make_flit(
    input logic [PADW-1:0]  pl,
    input logic [TW1-1:0]   tid,
    input logic [SW1-1:0]   src,
    input logic             op,
    input logic [IDX_W-1:0] idx,
    input logic [IDX_W-1:0] last
  );
    logic [63:0]           hdr;
    logic [1:0]            ty;
    logic [FLIT_WIDTH-1:0] f;
    if (last == '0)      ty = FLIT_SINGLE;
    else if (idx == '0)  ty = FLIT_HEAD;
    else if (idx == last) ty = FLIT_TAIL;
    else                 ty = FLIT_BODY;
    if (idx == '0) begin
      hdr = 64'(op) | (SLV_FIELD << 1) | (64'(src) << (1 + SLV_W))
          | (64'(tid) << (1 + SLV_W + SRC_W));
      f = (FLIT_WIDTH'(pl) << HF) | (FLIT_WIDTH'(hdr) << FFW) | FLIT_WIDTH'(ty);
    end else begin
      f = (FLIT_WIDTH'(pl >> (ROOM0 + (int'(idx) - 1) * ROOMK)) << HS)
        | (FLIT_WIDTH'(op) << FFW) | FLIT_WIDTH'(ty);
    end
    return f;
  endfunction

  state_e                state_q;
  logic [IDX_W-1:0]      idx_q, last_q, idx_d;
  logic [PADW-1:0]       pl_q;
  logic [TW1-1:0]        tid_q;
  logic [SW1-1:0]        src_q;
  logic                  op_q, ptr_q, lock_q, valid_q;
  logic [FLIT_WIDTH-1:0] flit_q;

  logic             load_s, gnt_b_s, gnt_r_s, b_ok_s;
  logic [TW1-1:0]   b_tid_s, r_tid_s;
  logic [SW1-1:0]   b_src_s, r_src_s;
  logic [PADW-1:0]  b_pl_s, r_pl_s;

  // Beat field extraction, load detection and round-robin/lock grant.
  always_comb begin
    b_tid_s = TW1'(rsp_if.b_chan) & TID_MASK;
    b_src_s = SW1'(rsp_if.b_chan >> TID_W) & SRC_MASK;
    b_pl_s  = PADW'(rsp_if.b_chan >> (TID_W + SRC_W));
    r_tid_s = TW1'(rsp_if.r_chan) & TID_MASK;
    r_src_s = SW1'(rsp_if.r_chan >> TID_W) & SRC_MASK;
    r_pl_s  = PADW'(rsp_if.r_chan >> (TID_W + SRC_W));
    idx_d   = idx_q + IDX_W'(1);
    b_ok_s  = rsp_if.b_valid && !lock_q;
    gnt_b_s = 1'b0;
    gnt_r_s = 1'b0;
    if (!rst_ni) begin
      load_s = 1'b0;
    end else if (state_q == ST_IDLE) begin
      load_s = 1'b1;
    end else begin
      load_s = rsp_if.ready_in && (idx_q == last_q);
    end
    if (load_s && b_ok_s && rsp_if.r_valid) begin
      gnt_b_s = !ptr_q;
      gnt_r_s = ptr_q;
    end else if (load_s) begin
      gnt_b_s = b_ok_s;
      gnt_r_s = rsp_if.r_valid;
    end else begin
      gnt_b_s = 1'b0;
      gnt_r_s = 1'b0;
    end
  end

  assign rsp_if.b_ready   = gnt_b_s;
  assign rsp_if.r_ready   = gnt_r_s;
  assign rsp_if.flit_out  = flit_q;
  assign rsp_if.valid_out = valid_q;

  // Packet FSM: capture a granted beat, then step through its flits on each handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      pl_q    <= '0;
      tid_q   <= '0;
      src_q   <= '0;
      op_q    <= 1'b0;
      ptr_q   <= 1'b0;
      lock_q  <= 1'b0;
      valid_q <= 1'b0;
      flit_q  <= '0;
    end else if (load_s && gnt_b_s) begin
      state_q <= ST_SEND;
      idx_q   <= '0;
      last_q  <= NB_LAST;
      pl_q    <= b_pl_s;
      tid_q   <= b_tid_s;
      src_q   <= b_src_s;
      op_q    <= OP_ID_WRITE;
      ptr_q   <= 1'b1;
      valid_q <= 1'b1;
      flit_q  <= make_flit(b_pl_s, b_tid_s, b_src_s, OP_ID_WRITE, '0, NB_LAST);
    end else if (load_s && gnt_r_s) begin
      state_q <= ST_SEND;
      idx_q   <= '0;
      last_q  <= NR_LAST;
      pl_q    <= r_pl_s;
      tid_q   <= r_tid_s;
      src_q   <= r_src_s;
      op_q    <= OP_ID_READ;
      ptr_q   <= 1'b0;
      lock_q  <= (LOCK_BURST != 0) && !rsp_if.r_last;
      valid_q <= 1'b1;
      flit_q  <= make_flit(r_pl_s, r_tid_s, r_src_s, OP_ID_READ, '0, NR_LAST);
    end else if (load_s) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      flit_q  <= '0;
    end else if (rsp_if.ready_in) begin
      idx_q  <= idx_d;
      flit_q <= make_flit(pl_q, tid_q, src_q, op_q, idx_d, last_q);
    end else begin
      flit_q <= flit_q;
    end
  end

endmodule

// File: doc/axi_resp_packetizer_rr.md
# axi_resp_packetizer_rr

Master-NI response packetizer with a built-in B/R merge and serializer: accepts AXI write-response (B) and read-data (R) beats on valid/ready handshakes, arbitrates round-robin between them, and emits each beat as a 1..N-flit NoC packet. The beat is carried by a full-header first flit and small-header body/tail flits. Width, header fields and flit width are parameters. Optional read-burst locking keeps an R burst contiguous on the link. It sits between the slave-side AXI response channels and the NoC response-path injection port.

## Interface
- SLAVE_ID, 0: slave index inserted in the full header (SLV_W bits)
- TID_W, 4: transaction-ID width (0 allowed, field omitted)
- SRC_W, 2: source-master index width (0 allowed)
- SLV_W, 1: slave-index width (0 allowed)
- B_PAYLOAD_W, 4: B payload bits (user+resp)
- R_PAYLOAD_W, 37: R payload bits (data+user+resp+last)
- FLIT_WIDTH, 32: output flit width; must exceed HF (defined under Operation)
- LOCK_BURST, 1: 1 = an R burst is not interleaved with B packets
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- b_chan  input  B_PAYLOAD_W+SRC_W+TID_W  {payload, src, tid}, tid at LSB
- b_valid  input  1  B beat valid
- b_ready  output  1  B beat accepted
- r_chan  input  R_PAYLOAD_W+SRC_W+TID_W  {payload, src, tid}
- r_last  input  1  final beat of R burst
- r_valid  input  1  R beat valid
- r_ready  output  1  R beat accepted
- flit_out  output  FLIT_WIDTH  flit
- valid_out  output  1  flit valid
- ready_in  input  1  NoC ready

## Operation
- Header widths: HF = TID_W+SRC_W+SLV_W+1+FLIT_FIELD_WIDTH; HS = 1+FLIT_FIELD_WIDTH. Op bit: OP_ID_WRITE for B, OP_ID_READ for R.
- Full header: {tid, src, SLAVE_ID, op}. Small header: {op}.
- Flit count for payload width P: N = 1 if P <= FLIT_WIDTH-HF; otherwise N = 1 + ceil((P-(FLIT_WIDTH-HF))/(FLIT_WIDTH-HS)). Computed separately for B and R at elaboration.
- Flit 0 = {payload[FLIT_WIDTH-HF-1:0], full header, type}.
- Flit k>0 = {next FLIT_WIDTH-HS payload bits, small header, type}.
- Unused MSBs of the last flit are zero.
- Type is FLIT_SINGLE if N=1; otherwise FLIT_HEAD, then FLIT_BODY for middle flits, then FLIT_TAIL.
- States:
  - IDLE: no packet held.
  - SEND: packet register holds one beat; flit counter idx indexes the current flit.
- Load condition: IDLE, or SEND with the last flit handshaken (valid_out & ready_in & idx==N-1). In a load cycle the arbiter grants one valid channel. The granted ready is asserted combinationally in that cycle; beat, op and N are captured, idx=0, state=SEND. With no valid channel, state goes to IDLE.
- Arbitration: a one-bit pointer selects the preferred channel. It toggles to the non-granted channel after every grant. Reset preference is B.
- Lock: when LOCK_BURST=1 and an R beat with r_last=0 is granted, the lock flag is set. While locked only R is granted, even if only B is valid. The flag clears when an R beat with r_last=1 is granted. With LOCK_BURST=0 the flag stays 0.
- SEND: valid_out=1 and flit_out = flit[idx]. On handshake with idx<N-1, idx increments. flit_out is stable while ready_in=0.
- Ready never asserts outside a load cycle. b_ready and r_ready are never both 1.
- Reset mid-packet: the in-flight packet is discarded, with no partial tail. An upstream beat already accepted is lost; this is system-level reset only.

## Timing
- Reset values: valid_out=0, flit_out=0, b_ready=0, r_ready=0, state=IDLE, pointer=B, lock=0, idx=0.
- Latency: beat accepted at edge t, flit 0 presented in cycle t+1. Flit k is presented no earlier than t+1+k.
- Throughput: 1 flit/cycle. The next packet loads in the same cycle its predecessor's last flit is accepted, so there is no bubble between packets.
- Output is registered: flit_out and valid_out have no combinational path from ready_in, b_valid or r_valid.
- b_ready and r_ready depend combinationally on b_valid, r_valid, ready_in and state.

## Test plan
- FLIT_WIDTH=32, TID_W=4, SRC_W=2, SLV_W=1, SLAVE_ID=1, B beat tid=5, src=2, payload=4'hA → b_ready in same cycle. Next cycle: one FLIT_SINGLE flit with header {5,2,1,OP_ID_WRITE}, payload 0xA, upper 18 bits zero.
- FLIT_WIDTH=24, R payload 37 bits, N=3. Hold ready_in=0 for 2 cycles on flit 1 → HEAD/BODY/TAIL in order, flit 1 stable while stalled. Payload bits [13:0], [34:14] and [36:35] appear with the tail zero-padded.
- b_valid and r_valid held high with single-flit packets and LOCK_BURST=0 → grants B,R,B,R. One flit per cycle, no idle cycles.
- LOCK_BURST=1, R burst of 4 beats with b_valid high throughout → all 4 R packets go out contiguously, then B. Repeat with LOCK_BURST=0 → B is interleaved after R beat 1.
- Back-to-back R multi-flit packets with ready_in=1 → the next HEAD follows the previous TAIL on the very next cycle. r_ready pulses in the TAIL-accept cycles.
- rst asserted mid-packet (after flit 1 of 3) → all outputs reset asynchronously. After release, a fresh B beat produces a correct FLIT_SINGLE with no stale TAIL emitted.
